uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  RS232 8N1 receiver: the counterpart of the team's UART transmitter on the same link.
//  Synchronises the asynchronous rx pin and detects the start-bit falling edge.
//  Samples each bit at mid-period and delivers one byte with a one-cycle valid pulse.
//  Sits between the board RX pin and loopback/user logic; po_data/po_flag feed a transmitter's pi_data/pi_flag directly.
// PARAMETERS
//  BAUD_MAX  115_200     line baud rate (bit/s)
//  CLK_MAX   50_000_000  sys_clk frequency (Hz)
//  derived: BAUD_CNT = CLK_MAX/BAUD_MAX (434 default); HALF = BAUD_CNT/2 (217); BAUD_CNT must be >= 8 and < 65536
// PORTS
//  sys_clk    in   1  system clock, all logic on rising edge
//  sys_rst_n  in   1  asynchronous active-low reset
//  rx         in   1  serial line, idle high, asynchronous to sys_clk
//  po_data    out  8  last correctly received byte, LSB first on line
//  po_flag    out  1  one-cycle pulse: po_data valid (new byte)
//  frame_err  out  1  one-cycle pulse: stop bit sampled low, byte discarded
//  rx_busy    out  1  high while state != IDLE
// BEHAVIOUR
//  Reset: po_data=8'h00, po_flag=0, frame_err=0, rx_busy=0, state IDLE, counters 0; sync flops rx_s1/rx_s2/rx_s3 reset to 1.
//  Sync: rx -> rx_s1 -> rx_s2 (2-FF metastability); rx_s3 = rx_s2 delayed; only rx_s2 is sampled.
//  Start edge: cycle E where state==IDLE && rx_s3==1 && rx_s2==0.
//  FSM states IDLE, START, DATA, STOP:
//   IDLE  -> START on start edge; baud_cnt<=0, bit_cnt<=0.
//   START -> at strobe: rx_s2==0 -> DATA; rx_s2==1 -> IDLE (glitch, no output pulse).
//   DATA  -> at strobe shift rx_s2 into shreg at bit position bit_cnt-1 (LSB first); after 8th data bit -> STOP.
//   STOP  -> at strobe: rx_s2==1 -> po_data<=shreg, po_flag<=1; rx_s2==0 -> frame_err<=1, po_data unchanged; both -> IDLE.
//  Timing:
//   baud_cnt (16 bit) counts 0..BAUD_CNT-1 in non-IDLE states, wraps to 0 and increments bit_cnt (0 start, 1..8 data, 9 stop).
//   strobe = (baud_cnt==HALF); bit k sampled in cycle E+1+k*BAUD_CNT+HALF.
//   po_flag/frame_err high exactly in cycle E+2+9*BAUD_CNT+HALF (E+4125 default), for one cycle.
//  po_data holds its value between frames; it changes only in the po_flag cycle.
//  Return to IDLE right after the stop sample; a start edge in the second half of the stop bit is accepted (back-to-back frames).
//  Edges during START/DATA/STOP are ignored; only strobe samples matter.
//  Line held low (break): one frame_err per low period; no new frame until rx_s2 returns high and falls again.
//  Reset mid-frame: immediate return to reset values; the partial byte is lost, with no flag or error pulse.
//  po_flag and frame_err are never high in the same cycle.
// TESTING
//  1 Reset, rx=1 for 10_000 cycles -> po_flag, frame_err and rx_busy stay 0; po_data=8'h00.
//  2 Frame 0x55, 434 cycles/bit -> a single po_flag at E+4125 with po_data=8'h55, frame_err=0; rx_busy drops in the same cycle.
//  3 Back-to-back 0xA3 then 0x0F, second start immediately after the first stop bit -> two po_flag pulses, data 8'hA3 then 8'h0F.
//  4 rx low for 100 cycles then high -> no po_flag or frame_err; rx_busy 1 from E+1 to the start strobe, then 0.
//  5 Data 0xFF with stop bit 0 (po_data previously 8'h55) -> frame_err pulse 1 cycle, no po_flag, po_data stays 8'h55.
//  6 Frames 0x3C at 425 and at 443 cycles/bit -> po_data=8'h3C each time. Reset pulsed mid-frame -> outputs 0, next 0x81 received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop synchroniser, start-edge detect, mid-bit sampling,
// one-cycle po_flag per good byte and one-cycle frame_err per bad stop bit.
module uart_rx #(
    parameter int BAUD_MAX = 115_200,
    parameter int CLK_MAX  = 50_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int          BAUD_CNT  = CLK_MAX / BAUD_MAX;
    localparam int          HALF      = BAUD_CNT / 2;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_CNT - 1);
    localparam logic [15:0] HALF_CNT  = 16'(HALF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_rx_s1;
    logic        r_rx_s2;
    logic        r_rx_s3;
    logic [15:0] r_baud_cnt;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shreg;
    logic        w_start_edge;
    logic        w_strobe;
    logic [2:0]  w_bit_idx;

    // Sync flops idle high so reset release never looks like a start edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    assign w_start_edge = (r_state == IDLE) && r_rx_s3 && !r_rx_s2;
    assign w_strobe     = (r_baud_cnt == HALF_CNT);
    assign w_bit_idx    = 3'(r_bit_cnt - 4'd1);
    assign rx_busy      = (r_state != IDLE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  if (w_start_edge) w_next_state = START;
            START: if (w_strobe) w_next_state = r_rx_s2 ? IDLE : DATA;
            DATA:  if (w_strobe && (r_bit_cnt == 4'd8)) w_next_state = STOP;
            STOP:  if (w_strobe) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // bit_cnt: 0 = start bit, 1..8 = data bits, 9 = stop bit.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_baud_cnt <= 16'd0;
            r_bit_cnt  <= 4'd0;
        end else if (r_state == IDLE) begin
            r_baud_cnt <= 16'd0;
            r_bit_cnt  <= 4'd0;
        end else if (r_baud_cnt == BAUD_LAST) begin
            r_baud_cnt <= 16'd0;
            r_bit_cnt  <= r_bit_cnt + 4'd1;
        end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_shreg   <= 8'h00;
            po_data   <= 8'h00;
            po_flag   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            po_flag   <= 1'b0;
            frame_err <= 1'b0;
            if ((r_state == DATA) && w_strobe) begin
                r_shreg[w_bit_idx] <= r_rx_s2;
            end
            if ((r_state == STOP) && w_strobe) begin
                if (r_rx_s2) begin
                    po_data <= r_shreg;
                    po_flag <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: scenario tasks drive the line; a negedge monitor pops the
// expected queue whenever the receiver reports a byte or a framing error.
module tb_uart_rx;

  localparam int BIT_CYC  = 434;
  localparam int FLAG_LAT = 4127;  // cycles from driving the start bit to the output pulse

  logic       sys_clk;
  logic       sys_rst_n;
  logic       rx;
  logic [7:0] po_data;
  logic       po_flag;
  logic       frame_err;
  logic       rx_busy;

  int         cyc;
  int         vectors;
  int         miscompares;
  logic [7:0] model_data;
  logic [7:0] prev_data;
  logic [8:0] exp_q[$];      // {expect_frame_err, expected po_data}
  int         exp_cyc_q[$];  // cycle in which the pulse must appear

  uart_rx dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx        (rx),
    .po_data   (po_data),
    .po_flag   (po_flag),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  // ---------------- clock / reset ----------------
  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // ---------------- scoreboard monitor ----------------
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (po_flag && frame_err) begin
        miscompares++;
        $display("FAIL flag_and_err_together cycle %0d: both high, required at most one", cyc);
      end
      if (po_data !== prev_data && !po_flag) begin
        miscompares++;
        $display("FAIL po_data_changed_without_flag cycle %0d: got %h, held %h", cyc, po_data, prev_data);
      end
      if (po_flag || frame_err) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_output cycle %0d: flag=%b err=%b data=%h, none expected",
                   cyc, po_flag, frame_err, po_data);
        end else begin
          logic [8:0] e;
          int         ec;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          if (frame_err !== e[8] || po_data !== e[7:0] || cyc != ec || rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_result: got err=%b data=%h cycle=%0d busy=%b, required err=%b data=%h cycle=%0d busy=0",
                     frame_err, po_data, cyc, rx_busy, e[8], e[7:0], ec);
          end
        end
      end
    end
    prev_data = po_data;
  end

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int bit_cyc, input logic stop_v);
    if (stop_v) model_data = d;
    exp_q.push_back({~stop_v, model_data});
    exp_cyc_q.push_back(cyc + FLAG_LAT);
    drive_bit(1'b0, bit_cyc);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bit_cyc);
    drive_bit(stop_v, bit_cyc);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    sys_rst_n  = 1'b0;
    rx         = 1'b1;
    model_data = 8'h00;
    repeat (5) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    repeat (10_000) begin
      @(negedge sys_clk);
      vectors++;
      if (po_flag !== 1'b0 || frame_err !== 1'b0 || rx_busy !== 1'b0 || po_data !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_idle cycle %0d: flag=%b err=%b busy=%b data=%h, required 0/0/0/00",
                 cyc, po_flag, frame_err, rx_busy, po_data);
      end
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_frame_55();
    send_frame(8'h55, BIT_CYC, 1'b1);
    drive_bit(1'b1, 50);
    vectors++;
    if (po_data !== 8'h55) begin
      miscompares++;
      $display("FAIL data_55_held: got %h, required 55", po_data);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(8'hA3, BIT_CYC, 1'b1);
    send_frame(8'h0F, BIT_CYC, 1'b1);
    drive_bit(1'b1, 50);
  endtask

  task automatic test_glitch();
    int c0;
    c0 = cyc;
    rx = 1'b0;
    for (int i = 0; i < 300; i++) begin
      logic exp_busy;
      @(negedge sys_clk);
      if (cyc == c0 + 100) rx = 1'b1;
      exp_busy = (cyc >= c0 + 3) && (cyc <= c0 + 220);
      vectors++;
      if (rx_busy !== exp_busy) begin
        miscompares++;
        $display("FAIL glitch_busy cycle %0d (start+%0d): got %b, required %b", cyc, cyc - c0, rx_busy, exp_busy);
      end
    end
    @(posedge sys_clk);
    #1;
    drive_bit(1'b1, 20);
  endtask

  task automatic test_frame_error();
    send_frame(8'h55, BIT_CYC, 1'b1);
    drive_bit(1'b1, 20);
    send_frame(8'hFF, BIT_CYC, 1'b0);
    drive_bit(1'b1, 50);
    vectors++;
    if (po_data !== 8'h55) begin
      miscompares++;
      $display("FAIL frame_err_keeps_data: got %h, required 55", po_data);
    end
  endtask

  task automatic test_baud_tolerance();
    send_frame(8'h3C, 425, 1'b1);
    drive_bit(1'b1, 30);
    send_frame(8'h3C, 443, 1'b1);
    drive_bit(1'b1, 30);
    for (int k = 0; k < 4; k++) begin
      send_frame(8'($urandom_range(0, 255)), $urandom_range(428, 440), 1'b1);
      drive_bit(1'b1, $urandom_range(1, 40));
    end
    send_frame(8'h3C, BIT_CYC, 1'b1);
    drive_bit(1'b1, 30);
  endtask

  task automatic test_reset_mid_frame();
    drive_bit(1'b0, BIT_CYC);
    drive_bit(1'b1, BIT_CYC);
    drive_bit(1'b0, BIT_CYC / 2);
    #3 sys_rst_n = 1'b0;
    model_data = 8'h00;
    @(negedge sys_clk);
    vectors++;
    if (po_data !== 8'h00 || rx_busy !== 1'b0 || po_flag !== 1'b0 || frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_frame_reset: data=%h busy=%b flag=%b err=%b, required 00/0/0/0",
               po_data, rx_busy, po_flag, frame_err);
    end
    rx = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    drive_bit(1'b1, 20);
    send_frame(8'h81, BIT_CYC, 1'b1);
    drive_bit(1'b1, 50);
    vectors++;
    if (po_data !== 8'h81) begin
      miscompares++;
      $display("FAIL after_reset_frame: got %h, required 81", po_data);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    cyc         = 0;
    vectors     = 0;
    miscompares = 0;
    prev_data   = 8'h00;
    test_reset();
    test_frame_55();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_baud_tolerance();
    test_reset_mid_frame();
    repeat (500) @(posedge sys_clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_outputs: %0d expected pulses never seen, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
